// File: rtl/trace_pkg.sv
// Shared types, record width and rd_data field offsets for the trace capture buffer.
// Record layout, MSB to LSB: {cyc, stage, pc, instr, mem_addr, mem_data, mem_write, mem_read}.
package trace_pkg;

   typedef enum logic [1:0] {IDLE, PRETRIG, POSTTRIG, DRAIN} state_t;

   localparam int unsigned STAGE_W = 3;
   localparam int unsigned MASK_W  = 8;

   function automatic int unsigned rec_w(input int unsigned cyc_w, input int unsigned data_w);
      return cyc_w + STAGE_W + 4 * data_w + 2;
   endfunction

   localparam int unsigned OFF_MEM_READ  = 0;
   localparam int unsigned OFF_MEM_WRITE = 1;

   function automatic int unsigned off_mem_data(input int unsigned data_w);
      return 2 + 0 * data_w;
   endfunction

   function automatic int unsigned off_mem_addr(input int unsigned data_w);
      return 2 + data_w;
   endfunction

   function automatic int unsigned off_instr(input int unsigned data_w);
      return 2 + 2 * data_w;
   endfunction

   function automatic int unsigned off_pc(input int unsigned data_w);
      return 2 + 3 * data_w;
   endfunction

   function automatic int unsigned off_stage(input int unsigned data_w);
      return 2 + 4 * data_w;
   endfunction

   function automatic int unsigned off_cyc(input int unsigned data_w);
      return 2 + 4 * data_w + STAGE_W;
   endfunction

endpackage

// File: rtl/trace_capture_buffer_if.sv
// Record read-out stream: valid/ready handshake carrying one trace record per transfer.
interface trace_capture_buffer_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned CYC_W  = 16
);
   localparam int unsigned REC_W = trace_pkg::rec_w(CYC_W, DATA_W);

   logic             rd_valid;
   logic             rd_ready;
   logic [REC_W-1:0] rd_data;
   logic             rd_last;

   modport master (output rd_valid, output rd_data, output rd_last, input rd_ready);
   modport slave  (input rd_valid, input rd_data, input rd_last, output rd_ready);
endinterface

// File: rtl/trace_ram.sv
// Record store: synchronous write, asynchronous read, array intentionally not reset.
module trace_ram #(
   parameter int unsigned DEPTH = 32,
   parameter int unsigned REC_W = 83,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [REC_W-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [REC_W-1:0] rdata
);
   logic [REC_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/trace_capture_buffer.sv
// Circular CPU trace capture: records qualified cycles, freezes on trigger plus a
// post-trigger window, then streams the history out oldest-first.
module trace_capture_buffer
   import trace_pkg::*;
#(
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned DEPTH      = 32,
   parameter int unsigned POST_DEPTH = 8,
   parameter int unsigned CYC_W      = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                arm,
   input  logic                abort,
   input  logic [MASK_W-1:0]   qual_mask,
   input  logic [DATA_W-1:0]   pc,
   input  logic [DATA_W-1:0]   instr,
   input  logic [DATA_W-1:0]   mem_addr,
   input  logic [DATA_W-1:0]   mem_data,
   input  logic                mem_write,
   input  logic                mem_read,
   input  logic [STAGE_W-1:0]  stage,
   input  logic                trig_pc_en,
   input  logic [DATA_W-1:0]   trig_pc,
   input  logic                trig_wr_en,
   input  logic [DATA_W-1:0]   trig_addr,
   input  logic                force_trig,
   trace_capture_buffer_if.master rd,
   output logic                busy,
   output logic                triggered,
   output logic                wrapped,
   output logic                done
);
   localparam int unsigned REC_W  = rec_w(CYC_W, DATA_W);
   localparam int unsigned AW     = $clog2(DEPTH);
   localparam int unsigned CNT_W  = AW + 1;
   localparam bit          NO_POST = (POST_DEPTH == 0);

   state_t             state, state_nxt;
   logic [CYC_W-1:0]   cyc;
   logic [AW-1:0]      wr_ptr, rd_ptr, wr_ptr_nxt;
   logic [CNT_W-1:0]   count, count_nxt, remaining, post;
   logic [REC_W-1:0]   ram_rdata;
   logic               qualified, hit, we, xfer, last_xfer;

   assign qualified = qual_mask[stage];
   assign hit = qualified && (force_trig || (trig_pc_en && (pc == trig_pc)) ||
                              (trig_wr_en && mem_write && (mem_addr == trig_addr)));
   assign we        = ((state == PRETRIG) || (state == POSTTRIG)) && qualified && !abort;
   assign xfer      = (state == DRAIN) && (remaining != '0) && rd.rd_ready;
   assign last_xfer = xfer && (remaining == CNT_W'(1));

   assign wr_ptr_nxt = we ? wr_ptr + AW'(1) : wr_ptr;
   assign count_nxt  = (we && (count != CNT_W'(DEPTH))) ? count + CNT_W'(1) : count;

   trace_ram #(.DEPTH(DEPTH), .REC_W(REC_W)) u_ram (
      .clk   (clk),
      .we    (we),
      .waddr (wr_ptr),
      .wdata ({cyc, stage, pc, instr, mem_addr, mem_data, mem_write, mem_read}),
      .raddr (rd_ptr),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Abort wins over every other transition.
   always_comb begin
      state_nxt = state;
      if (abort) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:     if (arm) state_nxt = PRETRIG;
            PRETRIG:  if (we && hit) state_nxt = NO_POST ? DRAIN : POSTTRIG;
            POSTTRIG: if (we && (post == CNT_W'(1))) state_nxt = DRAIN;
            DRAIN:    if ((remaining == '0) || last_xfer) state_nxt = IDLE;
            default:  state_nxt = IDLE;
         endcase
      end
   end

   // rd_data is forced to zero outside a valid beat so reset clears it immediately.
   always_comb begin
      rd.rd_valid = 1'b0;
      rd.rd_last  = 1'b0;
      rd.rd_data  = '0;
      busy        = (state != IDLE);
      if ((state == DRAIN) && (remaining != '0)) begin
         rd.rd_valid = 1'b1;
         rd.rd_last  = (remaining == CNT_W'(1));
         rd.rd_data  = ram_rdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cyc       <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         remaining <= '0;
         post      <= '0;
         triggered <= 1'b0;
         wrapped   <= 1'b0;
         done      <= 1'b0;
      end else begin
         cyc  <= cyc + CYC_W'(1);
         done <= last_xfer && !abort;
         if ((state == IDLE) && arm && !abort) begin
            wr_ptr    <= '0;
            count     <= '0;
            triggered <= 1'b0;
            wrapped   <= 1'b0;
         end
         if (we) begin
            wr_ptr <= wr_ptr_nxt;
            count  <= count_nxt;
            if ((state == PRETRIG) && (count == CNT_W'(DEPTH))) wrapped <= 1'b1;
            if ((state == PRETRIG) && hit) begin
               triggered <= 1'b1;
               post      <= CNT_W'(POST_DEPTH);
            end else if ((state == POSTTRIG) && (post != '0)) begin
               post <= post - CNT_W'(1);
            end
         end
         // Oldest record sits count entries behind the post-write pointer.
         if ((state_nxt == DRAIN) && (state != DRAIN)) begin
            rd_ptr    <= wr_ptr_nxt - AW'(count_nxt);
            remaining <= count_nxt;
         end else if (xfer) begin
            rd_ptr    <= rd_ptr + AW'(1);
            remaining <= remaining - CNT_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_trace_capture_buffer.sv
// Scoreboard bench: a queue-based reference model predicts the frozen history, drains compare it.
module tb_trace_capture_buffer;
   import trace_pkg::*;

   localparam int unsigned DW    = 16;
   localparam int unsigned CW    = 16;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned POST  = 3;
   localparam int unsigned REC_W = rec_w(CW, DW);
   localparam int unsigned O_PC  = off_pc(DW);
   localparam int unsigned O_STG = off_stage(DW);
   localparam int unsigned O_CYC = off_cyc(DW);

   typedef logic [REC_W-1:0] rec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic arm = 1'b0, abort = 1'b0, force_trig = 1'b0;
   logic [7:0] qual_mask = 8'hFF;
   logic [DW-1:0] pc = '0, instr = '0, mem_addr = '0, mem_data = '0, trig_pc = '0, trig_addr = '0;
   logic mem_write = 1'b0, mem_read = 1'b0, trig_pc_en = 1'b0, trig_wr_en = 1'b0;
   logic [2:0] stage = '0;
   logic busy, triggered, wrapped, done;
   logic [CW-1:0] tb_cyc;

   int errors = 0;
   int checks = 0;

   // Reference model state.
   state_t ms = IDLE;
   rec_t   mq[$];
   int     m_post = 0;
   bit     m_trig = 0, m_wrap = 0;
   bit     pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   trace_capture_buffer_if #(.DATA_W(DW), .CYC_W(CW)) rd_if ();

   trace_capture_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .POST_DEPTH(POST), .CYC_W(CW)) dut (
      .clk(clk), .rst(rst), .arm(arm), .abort(abort), .qual_mask(qual_mask),
      .pc(pc), .instr(instr), .mem_addr(mem_addr), .mem_data(mem_data),
      .mem_write(mem_write), .mem_read(mem_read), .stage(stage),
      .trig_pc_en(trig_pc_en), .trig_pc(trig_pc), .trig_wr_en(trig_wr_en),
      .trig_addr(trig_addr), .force_trig(force_trig), .rd(rd_if.master),
      .busy(busy), .triggered(triggered), .wrapped(wrapped), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk or posedge rst) begin
      if (rst) tb_cyc <= '0;
      else     tb_cyc <= tb_cyc + CW'(1);
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Predict the DUT's reaction to the inputs currently applied, for the coming edge.
   task automatic model_tick();
      bit q, h;
      rec_t r;
      q = qual_mask[stage];
      h = q && (force_trig || (trig_pc_en && pc == trig_pc) ||
                (trig_wr_en && mem_write && mem_addr == trig_addr));
      if (abort) begin
         ms = IDLE;
         return;
      end
      case (ms)
         IDLE: if (arm) begin
            mq.delete();
            m_trig = 0;
            m_wrap = 0;
            ms = PRETRIG;
         end
         PRETRIG, POSTTRIG: if (q) begin
            r = {tb_cyc, stage, pc, instr, mem_addr, mem_data, mem_write, mem_read};
            if (mq.size() == DEPTH) begin
               void'(mq.pop_front());
               if (ms == PRETRIG) m_wrap = 1;
            end
            mq.push_back(r);
            if (ms == PRETRIG) begin
               if (h) begin
                  m_trig = 1;
                  m_post = POST;
                  ms = (POST == 0) ? DRAIN : POSTTRIG;
               end
            end else begin
               m_post--;
               if (m_post == 0) ms = DRAIN;
            end
         end
         default: ;
      endcase
   endtask

   task automatic drive(input logic [DW-1:0] p, input logic [2:0] s, input bit ft);
      pc = p;
      stage = s;
      instr = p ^ 16'hA5A5;
      mem_addr = p + 16'h1000;
      mem_data = DW'($urandom);
      mem_write = p[0];
      mem_read = ~p[0];
      force_trig = ft;
      model_tick();
      step();
      force_trig = 1'b0;
   endtask

   task automatic do_arm(input bit ft);
      arm = 1'b1;
      force_trig = ft;
      model_tick();
      step();
      arm = 1'b0;
      force_trig = 1'b0;
   endtask

   // Pop/compare the scoreboard as the DUT streams records; stops early after max_xfer.
   task automatic drain(input bit toggle, input int exp_n, input int max_xfer, input bit stage2);
      int n = 0, k = 0, guard = 0;
      rec_t held = '0;
      bit stalled = 0, have_cyc = 0;
      logic [CW-1:0] last_cyc = '0;
      while (mq.size() != 0 && guard < 200 && n < max_xfer) begin
         rd_if.rd_ready = toggle ? pat[k % 4] : 1'b1;
         k++;
         check("rd_valid", rd_if.rd_valid, 1'b1);
         if (stalled) check("stall_hold", rd_if.rd_data, held);
         check("rd_data", rd_if.rd_data, mq[0]);
         check("rd_last", rd_if.rd_last, mq.size() == 1);
         if (stage2) check("stage_field", rd_if.rd_data[O_STG +: 3], 3'd2);
         if (rd_if.rd_ready) begin
            if (have_cyc) check("cyc_order", rd_if.rd_data[O_CYC +: CW] > last_cyc, 1'b1);
            last_cyc = rd_if.rd_data[O_CYC +: CW];
            have_cyc = 1;
            void'(mq.pop_front());
            n++;
            stalled = 0;
         end else begin
            stalled = 1;
            held = rd_if.rd_data;
         end
         step();
         guard++;
      end
      rd_if.rd_ready = 1'b0;
      if (n < max_xfer) begin
         check("drain_count", n, exp_n);
         check("done_pulse", done, 1'b1);
         check("busy_after", busy, 1'b0);
         check("valid_after", rd_if.rd_valid, 1'b0);
         ms = IDLE;
         step();
         check("done_once", done, 1'b0);
      end
   endtask

   initial begin
      rd_if.rd_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_valid", rd_if.rd_valid, 1'b0);
      check("rst_data", rd_if.rd_data, '0);
      check("rst_trig", triggered, 1'b0);
      check("rst_done", done, 1'b0);
      @(negedge clk) rst = 1'b0;
      step();

      // PC trigger with wrap; force_trig in the arm cycle must be ignored.
      trig_pc_en = 1'b1;
      trig_pc = 16'd10;
      do_arm(1'b1);
      check("arm_busy", busy, 1'b1);
      for (int i = 0; i < 20; i++) drive(DW'(i), 3'd0, 1'b0);
      trig_pc_en = 1'b0;
      check("s1_trig", triggered, m_trig);
      check("s1_wrap", wrapped, m_wrap);
      check("s1_first_pc", mq[0][O_PC +: DW], 16'd6);
      drain(1'b0, 8, 100, 1'b0);

      // Force trigger on the second write, short session.
      do_arm(1'b0);
      drive(16'd100, 3'd1, 1'b0);
      drive(16'd101, 3'd1, 1'b1);
      for (int i = 102; i < 105; i++) drive(DW'(i), 3'd1, 1'b0);
      check("s2_trig", triggered, 1'b1);
      check("s2_wrap", wrapped, 1'b0);
      check("s2_count", mq.size(), 5);
      drain(1'b0, 5, 100, 1'b0);

      // Stage qualification with stalling consumer.
      qual_mask = 8'b0000_0100;
      trig_pc_en = 1'b1;
      trig_pc = 16'd203;
      do_arm(1'b0);
      for (int i = 0; i < 36; i++) begin
         if (i == 11) check("s3_no_trig", triggered, 1'b0);
         if (i == 12) trig_pc = 16'd217;
         drive(DW'(200 + i), 3'(i % 5), 1'b0);
      end
      trig_pc_en = 1'b0;
      check("s3_trig", triggered, m_trig);
      check("s3_wrap", wrapped, 1'b0);
      drain(1'b1, 7, 100, 1'b1);
      qual_mask = 8'hFF;

      // Abort in POSTTRIG, then a fresh session on a store-address trigger.
      do_arm(1'b0);
      drive(16'd300, 3'd0, 1'b0);
      drive(16'd301, 3'd0, 1'b0);
      drive(16'd302, 3'd0, 1'b1);
      drive(16'd303, 3'd0, 1'b0);
      abort = 1'b1;
      model_tick();
      step();
      abort = 1'b0;
      check("abort_busy", busy, 1'b0);
      check("abort_valid", rd_if.rd_valid, 1'b0);
      step();
      check("abort_done", done, 1'b0);
      trig_wr_en = 1'b1;
      trig_addr = 16'h1000 + 16'd311;
      do_arm(1'b0);
      check("rearm_trig", triggered, 1'b0);
      check("rearm_busy", busy, 1'b1);
      for (int i = 310; i < 315; i++) drive(DW'(i), 3'd0, 1'b0);
      trig_wr_en = 1'b0;
      check("s4_trig", triggered, 1'b1);
      drain(1'b0, 5, 100, 1'b0);

      // Async reset in the middle of a drain.
      do_arm(1'b0);
      for (int i = 0; i < 12; i++) drive(DW'(400 + i), 3'd0, i == 8);
      drain(1'b0, 8, 3, 1'b0);
      rst = 1'b1;
      #1;
      check("mid_rst_valid", rd_if.rd_valid, 1'b0);
      check("mid_rst_data", rd_if.rd_data, '0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_trig", triggered, 1'b0);
      check("mid_rst_wrap", wrapped, 1'b0);
      check("mid_rst_done", done, 1'b0);
      ms = IDLE;
      mq.delete();
      @(negedge clk) rst = 1'b0;
      step();
      step();
      check("post_rst_done", done, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
